// File: rtl/debug_module_if.sv
// DMI strobe/address bundle from the DTM plus the hart-side halt/resume and
// abstract register port of the debug module.
interface debug_module_if;
  logic        dmi_read;
  logic        dmi_write;
  logic [6:0]  dmi_address;

  logic        ndmreset;
  logic        hart_halt_req;
  logic        hart_resume_req;
  logic        hart_halted;

  logic        hart_reg_req;
  logic        hart_reg_we;
  logic [4:0]  hart_reg_addr;
  logic [31:0] hart_reg_wdata;
  logic [31:0] hart_reg_rdata;
  logic        hart_reg_ack;

  modport slave (
    input  dmi_read,
    input  dmi_write,
    input  dmi_address,
    output ndmreset,
    output hart_halt_req,
    output hart_resume_req,
    input  hart_halted,
    output hart_reg_req,
    output hart_reg_we,
    output hart_reg_addr,
    output hart_reg_wdata,
    input  hart_reg_rdata,
    input  hart_reg_ack
  );

  modport master (
    output dmi_read,
    output dmi_write,
    output dmi_address,
    input  ndmreset,
    input  hart_halt_req,
    input  hart_resume_req,
    output hart_halted,
    input  hart_reg_req,
    input  hart_reg_we,
    input  hart_reg_addr,
    input  hart_reg_wdata,
    output hart_reg_rdata,
    output hart_reg_ack
  );
endinterface

// File: rtl/debug_module.sv
// RISC-V debug module subset: DMI register file, single-hart halt/resume
// handshake and abstract GPR access through a request/ack register port.
module debug_module #(
  parameter int unsigned ABS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  debug_module_if.slave     dbg,
  inout  wire  [31:0]       dmi_data
);

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;

  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  localparam int unsigned     CNT_W    = $clog2(ABS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ABS_TIMEOUT - 1);

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_BUSY = 3'd1;
  localparam logic [2:0] ERR_NOTSUP = 3'd2;
  localparam logic [2:0] ERR_EXCEPT = 3'd3;
  localparam logic [2:0] ERR_HALTRESUME = 3'd4;

  typedef enum logic [0:0] {
    ABS_IDLE,
    ABS_REQ
  } abs_state_e;

  abs_state_e       state_q, state_d;
  logic             dmactive_q, dmactive_d;
  logic             ndmreset_q, ndmreset_d;
  logic             haltreq_q, haltreq_d;
  logic             resume_req_q, resume_req_d;
  logic             resumeack_q, resumeack_d;
  logic [31:0]      data0_q, data0_d;
  logic [2:0]       cmderr_q, cmderr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reg_we_q, reg_we_d;
  logic [4:0]       reg_addr_q, reg_addr_d;

  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        wr_data0;
  logic        wr_dmcontrol;
  logic        wr_abstractcs;
  logic        wr_command;
  logic        cmd_bad;
  logic        unused_wdata;

  assign wdata        = dmi_data;
  assign unused_wdata = ^wdata;
  assign busy         = (state_q == ABS_REQ);

  assign wr_data0      = dbg.dmi_write && (dbg.dmi_address == ADDR_DATA0);
  assign wr_dmcontrol  = dbg.dmi_write && (dbg.dmi_address == ADDR_DMCONTROL);
  assign wr_abstractcs = dbg.dmi_write && (dbg.dmi_address == ADDR_ABSTRACTCS);
  assign wr_command    = dbg.dmi_write && (dbg.dmi_address == ADDR_COMMAND);

  // Only access-register (cmdtype 0), 32-bit, GPR regnos 0x1000-0x101F are supported.
  assign cmd_bad = (wdata[31:24] != 8'd0) || (wdata[22:20] != 3'd2) ||
                   (wdata[17] && (wdata[15:5] != 11'h080));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ABS_IDLE;
      dmactive_q   <= 1'b0;
      ndmreset_q   <= 1'b0;
      haltreq_q    <= 1'b0;
      resume_req_q <= 1'b0;
      resumeack_q  <= 1'b0;
      data0_q      <= '0;
      cmderr_q     <= ERR_NONE;
      cnt_q        <= '0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      dmactive_q   <= dmactive_d;
      ndmreset_q   <= ndmreset_d;
      haltreq_q    <= haltreq_d;
      resume_req_q <= resume_req_d;
      resumeack_q  <= resumeack_d;
      data0_q      <= data0_d;
      cmderr_q     <= cmderr_d;
      cnt_q        <= cnt_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dmactive_d   = dmactive_q;
    ndmreset_d   = ndmreset_q;
    haltreq_d    = haltreq_q;
    resume_req_d = resume_req_q;
    resumeack_d  = resumeack_q;
    data0_d      = data0_q;
    cmderr_d     = cmderr_q;
    cnt_d        = cnt_q;
    reg_we_d     = reg_we_q;
    reg_addr_d   = reg_addr_q;

    if (wr_dmcontrol) begin
      dmactive_d = wdata[0];
      ndmreset_d = wdata[1];
      haltreq_d  = wdata[31];
    end

    if (resume_req_q && !dbg.hart_halted) begin
      resume_req_d = 1'b0;
      resumeack_d  = 1'b1;
    end
    if (wr_dmcontrol && wdata[30] && !wdata[31]) begin
      resume_req_d = 1'b1;
      resumeack_d  = 1'b0;
    end

    // Any write that would disturb an in-flight command is dropped and flagged.
    if (busy && (wr_data0 || wr_abstractcs || wr_command) && (cmderr_q == ERR_NONE)) begin
      cmderr_d = ERR_BUSY;
    end

    if (!busy) begin
      if (wr_data0) begin
        data0_d = wdata;
      end
      if (wr_abstractcs) begin
        cmderr_d = cmderr_q & ~wdata[10:8];
      end
      if (wr_command && (cmderr_q == ERR_NONE)) begin
        if (cmd_bad) begin
          cmderr_d = ERR_NOTSUP;
        end else if (!dbg.hart_halted) begin
          cmderr_d = ERR_HALTRESUME;
        end else if (wdata[17]) begin
          state_d    = ABS_REQ;
          cnt_d      = '0;
          reg_we_d   = wdata[16];
          reg_addr_d = wdata[4:0];
        end
      end
    end

    case (state_q)
      ABS_REQ: begin
        if (dbg.hart_reg_ack) begin
          if (!reg_we_q) begin
            data0_d = dbg.hart_reg_rdata;
          end
          state_d = ABS_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ABS_IDLE;
          cnt_d   = '0;
          if (cmderr_d == ERR_NONE) begin
            cmderr_d = ERR_EXCEPT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase

    // Clearing dmactive returns every piece of DM state to its reset value.
    if (!dmactive_d) begin
      state_d      = ABS_IDLE;
      ndmreset_d   = 1'b0;
      haltreq_d    = 1'b0;
      resume_req_d = 1'b0;
      resumeack_d  = 1'b0;
      data0_d      = '0;
      cmderr_d     = ERR_NONE;
      cnt_d        = '0;
      reg_we_d     = 1'b0;
      reg_addr_d   = '0;
    end
  end

  always_comb begin
    rdata = '0;
    case (dbg.dmi_address)
      ADDR_DATA0:      rdata = data0_q;
      ADDR_DMCONTROL:  rdata = {haltreq_q, 29'd0, ndmreset_q, dmactive_q};
      ADDR_DMSTATUS:   rdata = {14'd0, resumeack_q, resumeack_q, 4'd0,
                                !dbg.hart_halted, !dbg.hart_halted,
                                dbg.hart_halted, dbg.hart_halted,
                                1'b1, 3'd0, 4'd2};
      ADDR_ABSTRACTCS: rdata = {3'd0, 5'd0, 11'd0, busy, 1'b0, cmderr_q, 4'd0, 4'd1};
      default:         rdata = '0;
    endcase
  end

  assign dmi_data = dbg.dmi_read ? rdata : 32'bz;

  assign dbg.ndmreset        = ndmreset_q;
  assign dbg.hart_halt_req   = haltreq_q & dmactive_q;
  assign dbg.hart_resume_req = resume_req_q;
  assign dbg.hart_reg_req    = busy;
  assign dbg.hart_reg_we     = busy & reg_we_q;
  assign dbg.hart_reg_addr   = busy ? reg_addr_q : 5'd0;
  assign dbg.hart_reg_wdata  = busy ? data0_q : 32'd0;

endmodule

// File: tb/tb_debug_module.sv
// Scoreboard bench for debug_module: stimulus pushes expectations, a negedge
// monitor pops and compares DMI read data, hart requests and sampled signals.
module tb_debug_module;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire  [31:0] dmi_data;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_wdata = 32'd0;

  assign dmi_data = tb_drv ? tb_wdata : 32'bz;

  debug_module_if dbg_if();

  debug_module #(.ABS_TIMEOUT(255)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dbg      (dbg_if),
    .dmi_data (dmi_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [37:0] req_exp_q[$];
  logic [31:0] gen_got_q[$];
  logic [31:0] gen_exp_q[$];
  string       gen_name_q[$];

  logic        req_prev = 1'b0;
  int          req_len = 0;
  logic [31:0] m_exp;
  logic [31:0] m_got;
  logic [37:0] m_req;
  string       m_name;

  // Monitor: every comparison of the run happens here.
  always @(negedge clk) begin
    if (rst_n && dbg_if.dmi_read) begin
      checks++;
      if (rd_exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read addr=%h got=%h", dbg_if.dmi_address, dmi_data);
      end else begin
        m_exp  = rd_exp_q.pop_front();
        m_name = rd_name_q.pop_front();
        if (dmi_data !== m_exp) begin
          errors++;
          $display("FAIL %s addr=%h got=%h expected=%h", m_name, dbg_if.dmi_address, dmi_data, m_exp);
        end else begin
          $display("read  %s addr=%h data=%h", m_name, dbg_if.dmi_address, dmi_data);
        end
      end
    end
    if (dbg_if.hart_reg_req && !req_prev) begin
      checks++;
      if (req_exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req we=%0d addr=%0d", dbg_if.hart_reg_we, dbg_if.hart_reg_addr);
      end else begin
        m_req = req_exp_q.pop_front();
        if ((dbg_if.hart_reg_we !== m_req[37]) || (dbg_if.hart_reg_addr !== m_req[36:32]) ||
            (m_req[37] && (dbg_if.hart_reg_wdata !== m_req[31:0]))) begin
          errors++;
          $display("FAIL hart_req got we=%0d addr=%0d wdata=%h expected we=%0d addr=%0d wdata=%h",
                   dbg_if.hart_reg_we, dbg_if.hart_reg_addr, dbg_if.hart_reg_wdata,
                   m_req[37], m_req[36:32], m_req[31:0]);
        end else begin
          $display("req   we=%0d addr=%0d wdata=%h", dbg_if.hart_reg_we, dbg_if.hart_reg_addr,
                   dbg_if.hart_reg_wdata);
        end
      end
    end
    if (dbg_if.hart_reg_req) begin
      req_len = req_prev ? req_len + 1 : 1;
    end
    req_prev = dbg_if.hart_reg_req;
    while (gen_exp_q.size() > 0) begin
      m_exp  = gen_exp_q.pop_front();
      m_got  = gen_got_q.pop_front();
      m_name = gen_name_q.pop_front();
      checks++;
      if (m_got !== m_exp) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", m_name, m_got, m_exp);
      end else begin
        $display("check %s value=%h", m_name, m_got);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    gen_name_q.push_back(name);
    gen_got_q.push_back(got);
    gen_exp_q.push_back(exp);
  endtask

  task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
    tick();
    dbg_if.dmi_write   = 1'b1;
    dbg_if.dmi_address = a;
    tb_wdata           = d;
    tb_drv             = 1'b1;
    tick();
    dbg_if.dmi_write   = 1'b0;
    tb_drv             = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic dmi_rd(input logic [6:0] a, input logic [31:0] exp, input string name);
    tick();
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    dbg_if.dmi_read    = 1'b1;
    dbg_if.dmi_address = a;
    tick();
    dbg_if.dmi_read    = 1'b0;
  endtask

  task automatic push_req(input logic we, input logic [4:0] addr, input logic [31:0] wd);
    req_exp_q.push_back({we, addr, wd});
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_if.hart_reg_req) return;
    end
    expect_val(name, 32'd0, 32'd1);
  endtask

  task automatic ack(input logic [31:0] rd);
    tick();
    dbg_if.hart_reg_ack   = 1'b1;
    dbg_if.hart_reg_rdata = rd;
    tick();
    dbg_if.hart_reg_ack   = 1'b0;
  endtask

  initial begin
    dbg_if.dmi_read       = 1'b0;
    dbg_if.dmi_write      = 1'b0;
    dbg_if.dmi_address    = 7'd0;
    dbg_if.hart_halted    = 1'b0;
    dbg_if.hart_reg_rdata = 32'd0;
    dbg_if.hart_reg_ack   = 1'b0;

    repeat (3) tick();
    expect_val("reset_outputs",
               {27'd0, dbg_if.ndmreset, dbg_if.hart_halt_req, dbg_if.hart_resume_req,
                dbg_if.hart_reg_req, dbg_if.hart_reg_we}, 32'd0);
    expect_val("reset_reg_port", {dbg_if.hart_reg_wdata[26:0], dbg_if.hart_reg_addr}, 32'd0);
    rst_n = 1'b1;

    dmi_rd(7'h11, 32'h0000_0C82, "dmstatus_reset");
    dmi_rd(7'h16, 32'h0000_0001, "abstractcs_reset");
    dmi_rd(7'h7F, 32'h0000_0000, "unimpl_7f");
    dmi_rd(7'h10, 32'h0000_0000, "dmcontrol_reset");
    dmi_rd(7'h17, 32'h0000_0000, "command_wo");

    // Halt, then resume handshake.
    dmi_wr(7'h10, 32'h8000_0001);
    expect_val("halt_req_set", {31'd0, dbg_if.hart_halt_req}, 32'd1);
    dmi_rd(7'h10, 32'h8000_0001, "dmcontrol_halt");
    dbg_if.hart_halted = 1'b1;
    dmi_rd(7'h11, 32'h0000_0382, "dmstatus_halted");
    dmi_wr(7'h10, 32'h4000_0001);
    expect_val("resume_req_set", {30'd0, dbg_if.hart_halt_req, dbg_if.hart_resume_req}, 32'd1);
    dmi_rd(7'h10, 32'h0000_0001, "dmcontrol_resumereq_reads0");
    repeat (3) tick();
    expect_val("resume_req_held", {31'd0, dbg_if.hart_resume_req}, 32'd1);
    dbg_if.hart_halted = 1'b0;
    tick();
    expect_val("resume_req_drop", {31'd0, dbg_if.hart_resume_req}, 32'd0);
    dmi_rd(7'h11, 32'h0003_0C82, "dmstatus_resumeack");

    // resumereq together with haltreq is ignored.
    dmi_wr(7'h10, 32'hC000_0001);
    expect_val("resume_ignored", {30'd0, dbg_if.hart_halt_req, dbg_if.hart_resume_req}, 32'd2);
    dbg_if.hart_halted = 1'b1;
    dmi_rd(7'h11, 32'h0003_0382, "dmstatus_rehalted");

    // Abstract GPR write.
    dmi_wr(7'h04, 32'hDEAD_BEEF);
    dmi_rd(7'h04, 32'hDEAD_BEEF, "data0_wr");
    push_req(1'b1, 5'd5, 32'hDEAD_BEEF);
    dmi_wr(7'h17, 32'h0023_1005);
    dmi_rd(7'h16, 32'h0000_1001, "abstractcs_busy");
    wait_req("timeout_req_x5");
    ack(32'h0);
    dmi_rd(7'h16, 32'h0000_0001, "abstractcs_done_wr");
    dmi_rd(7'h04, 32'hDEAD_BEEF, "data0_after_wr");

    // Abstract GPR reads, including the top regno.
    push_req(1'b0, 5'd31, 32'h0);
    dmi_wr(7'h17, 32'h0022_101F);
    wait_req("timeout_req_x31");
    ack(32'hA5A5_0001);
    dmi_rd(7'h04, 32'hA5A5_0001, "data0_x31");
    push_req(1'b0, 5'd2, 32'h0);
    dmi_wr(7'h17, 32'h0022_1002);
    wait_req("timeout_req_x2");
    ack(32'h1234_5678);
    dmi_rd(7'h04, 32'h1234_5678, "data0_x2");
    dmi_rd(7'h16, 32'h0000_0001, "abstractcs_done_rd");

    // Unsupported regno, then transfer=0 completes with no access.
    dmi_wr(7'h17, 32'h0022_1020);
    dmi_rd(7'h16, 32'h0000_0201, "cmderr_notsup");
    dmi_wr(7'h16, 32'h0000_0700);
    dmi_wr(7'h17, 32'h0020_0000);
    dmi_rd(7'h16, 32'h0000_0001, "no_transfer");

    // Command while running, and while cmderr is set.
    dbg_if.hart_halted = 1'b0;
    dmi_wr(7'h17, 32'h0022_1002);
    dmi_rd(7'h16, 32'h0000_0401, "cmderr_running");
    dbg_if.hart_halted = 1'b1;
    dmi_wr(7'h17, 32'h0022_1002);
    expect_val("no_req_with_cmderr", {31'd0, dbg_if.hart_reg_req}, 32'd0);
    dmi_rd(7'h16, 32'h0000_0401, "cmderr_sticky");
    dmi_wr(7'h16, 32'h0000_0700);
    dmi_rd(7'h16, 32'h0000_0001, "cmderr_cleared");

    // Busy collisions, then timeout with no ack.
    push_req(1'b0, 5'd1, 32'h0);
    dmi_wr(7'h17, 32'h0022_1001);
    wait_req("timeout_req_x1");
    dmi_wr(7'h17, 32'h0022_1001);
    dmi_rd(7'h16, 32'h0000_1101, "cmderr_busy");
    dmi_wr(7'h04, 32'hCAFE_F00D);
    dmi_rd(7'h04, 32'h1234_5678, "data0_busy_ignored");
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!dbg_if.hart_reg_req) break;
    end
    expect_val("req_dropped", {31'd0, dbg_if.hart_reg_req}, 32'd0);
    expect_val("req_len", req_len, 32'd255);
    dmi_rd(7'h16, 32'h0000_0101, "cmderr_after_timeout");
    ack(32'h5555_5555);
    dmi_rd(7'h04, 32'h1234_5678, "late_ack_ignored");

    // dmactive cleared mid-command.
    dmi_wr(7'h16, 32'h0000_0700);
    push_req(1'b0, 5'd3, 32'h0);
    dmi_wr(7'h17, 32'h0022_1003);
    wait_req("timeout_req_x3");
    dmi_wr(7'h10, 32'h0000_0000);
    expect_val("deactivate_outputs", {30'd0, dbg_if.hart_halt_req, dbg_if.hart_reg_req}, 32'd0);
    dmi_rd(7'h16, 32'h0000_0001, "abstractcs_deactivated");
    dmi_rd(7'h04, 32'h0000_0000, "data0_deactivated");
    dmi_rd(7'h10, 32'h0000_0000, "dmcontrol_deactivated");
    dmi_wr(7'h10, 32'h0000_0003);
    expect_val("ndmreset_set", {31'd0, dbg_if.ndmreset}, 32'd1);
    dmi_rd(7'h10, 32'h0000_0003, "dmcontrol_ndmreset");

    repeat (3) tick();
    expect_val("scoreboard_drained", rd_exp_q.size() + req_exp_q.size(), 32'd0);
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end
endmodule
